byte_hex_display: RTL
=====================

Name: byte_hex_display

Overview:
- Downstream consumer of the 8-bit concatenated nibble pair {A,B}.
- Latches the byte on a load strobe and shows it as two hex digits on a two-digit, time-multiplexed, common-anode seven-segment display.
- Digit 1 shows the high nibble (A); digit 0 shows the low nibble (B).
- Sits between the concatenation stage and the board display pins.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit before the scan advances. Legal range is REFRESH_DIV >= 2. Benches use 4.
- CNT_W, 17: width of the refresh counter. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  when high at a rising clk edge, byte_in is captured.
- byte_in  input  8  byte to display: [7:4] is the high digit, [3:0] is the low digit.
- blank_lz  input  1  leading-zero blank. When high and the high nibble is 0, digit 1 stays dark.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  output  2  digit anodes, active-low, registered. an[0] drives digit 0 (low nibble).
- shown  output  8  currently latched byte, registered.

Behaviour:
- Reset (rst high, asynchronous, effective immediately without a clock edge):
  - byte_reg = 8'h00, shown = 8'h00
  - cnt = 0, sel = 0
  - an = 2'b11 (all dark), seg = 7'h7F
  - All values hold while rst is high.
- Load:
  - load=1 at edge k sets byte_reg <= byte_in at edge k; shown equals byte_reg.
  - load=0 holds the value.
  - Load does not touch cnt or sel, so the scan continues uninterrupted.
- Refresh counter:
  - At each edge, if cnt == REFRESH_DIV-1, then cnt <= 0 and sel <= ~sel.
  - Otherwise cnt <= cnt + 1.
  - sel=0 selects digit 0; sel=1 selects digit 1.
- Output register: at each edge, seg and an are computed from the pre-edge sel and byte_reg.
  - Outputs lag sel and byte_reg by one cycle.
  - The first edge after rst deasserts produces an = 2'b10 and seg = decode(byte_reg[3:0]).
  - A load at edge k is visible on seg at edge k+1 if its digit is selected.
- Digit select mapping:
  - sel=0: an = 2'b10, seg = decode(byte_reg[3:0]).
  - sel=1: an = 2'b01, seg = decode(byte_reg[7:4]).
  - sel=1 with blank_lz=1 and byte_reg[7:4] == 0: an = 2'b11, seg = 7'h7F.
  - Digit 0 is never blanked.
- Hex decode, active-low {g..a}:
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E
- Dwell and cadence:
  - Each digit is lit for exactly REFRESH_DIV consecutive cycles.
  - Full scan period is 2*REFRESH_DIV cycles.
  - At most one anode is low at any time.
- Boundary cases:
  - Load on the same edge as a sel toggle: the new byte and the new sel both apply at the next output update.
  - Back-to-back loads: the last one wins.
  - Reset mid-scan: everything returns to reset values immediately, and the scan restarts at digit 0.
  - blank_lz changes take effect at the next output register update.

Test Plan:
- Reset then release with REFRESH_DIV=4 -> an=11, seg=7F during reset; first edge after release gives an=10, seg=40. Thereafter an alternates every 4 cycles: 10,10,10,10,01,01,01,01.
- load=1 with byte_in=8'h3C -> shown=3C. Digit 0 slot shows seg=46 with an=10; digit 1 slot shows seg=30 with an=01.
- Load 8'h0A, blank_lz=1 -> digit 0 shows seg=08, an=10; digit 1 slot shows an=11, seg=7F. Set blank_lz=0 -> digit 1 shows seg=40, an=01.
- Loads stepping through 8'h00 to 8'hFF in steps of 8'h11 -> every decoded seg code matches the hex table on both digits; at most one an bit is low at any time.
- Load 8'h12 in the middle of the digit 0 slot -> seg changes from the old low-nibble code to 24 one cycle after the load edge; the digit boundary does not move.
- Assert rst during cnt=2 of a digit 1 slot -> an=11, seg=7F, shown=00 immediately. After release, the scan restarts at digit 0 with a full 4-cycle dwell.

Source files
------------

// File: rtl/byte_hex_display_if.sv
// byte_hex_display_if: load/byte strobe in, seven-segment pins and latched byte out.
interface byte_hex_display_if;
    logic       load;
    logic [7:0] byte_in;
    logic       blank_lz;
    logic [6:0] seg;
    logic [1:0] an;
    logic [7:0] shown;
    modport master (output load, byte_in, blank_lz, input seg, an, shown);
    modport slave  (input load, byte_in, blank_lz, output seg, an, shown);
endinterface

// File: rtl/byte_hex_display.sv
// byte_hex_display: latches a byte and scans it as two hex digits on a common-anode,
// time-multiplexed seven-segment display.
module byte_hex_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input logic               clk,
    input logic               rst,
    byte_hex_display_if.slave bus
);
    logic [7:0]       r_byte;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;
    logic [6:0]       r_seg;
    logic [1:0]       r_an;
    logic [3:0]       w_nib;
    logic             w_blank;
    logic             w_wrap;
    logic [6:0]       w_seg;
    logic [1:0]       w_an;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        w_wrap  = r_cnt == CNT_W'(REFRESH_DIV - 1);
        w_nib   = r_sel ? r_byte[7:4] : r_byte[3:0];
        w_blank = r_sel && bus.blank_lz && r_byte[7:4] == 4'h0;
        w_seg   = w_blank ? 7'h7F : hex7(w_nib);
        w_an    = w_blank ? 2'b11 : (r_sel ? 2'b01 : 2'b10);
    end

    // Outputs are computed from pre-edge sel/byte, so they trail the scan by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte <= 8'h00;
            r_cnt  <= '0;
            r_sel  <= 1'b0;
            r_seg  <= 7'h7F;
            r_an   <= 2'b11;
        end else begin
            if (bus.load) r_byte <= bus.byte_in;
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            r_sel <= r_sel ^ w_wrap;
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign bus.seg   = r_seg;
    assign bus.an    = r_an;
    assign bus.shown = r_byte;
endmodule
